// File: rtl/fb_dump_pkg.sv
// Shared types and defaults for the frame-buffer UART dump engine.
// Contents: NES frame geometry, default sync header bytes, the colour-index
// type shared with vga_fb, and the dump FSM state encoding.
// Optional feature macro: FB_DUMP_CSUM_EN adds the CSUM state.
package fb_dump_pkg;

  localparam int unsigned NES_H_PIX = 256;
  localparam int unsigned NES_V_PIX = 240;

  localparam logic [7:0] FB_SYNC0 = 8'hA5;
  localparam logic [7:0] FB_SYNC1 = 8'h5A;

  typedef logic [5:0] color_idx_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR0 = 3'd1,
    ST_HDR1 = 3'd2,
    ST_RD   = 3'd3,
    ST_CAP  = 3'd4,
    ST_SEND = 3'd5,
`ifdef FB_DUMP_CSUM_EN
    ST_CSUM = 3'd6,
`endif
    ST_FIN  = 3'd7
  } fb_dump_state_t;

endpackage

// File: rtl/fb_uart_dump.sv
// Frame-buffer readback engine: on start, sends a two-byte sync header, then
// reads every pixel of the frame buffer in raster order and sends each 6-bit
// colour index as one byte over a valid/ready UART TX interface.
// Optional feature macro: FB_DUMP_CSUM_EN appends a mod-256 sum of all pixel
// bytes after the last pixel.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   start, abort           dump request pulse, level abort at byte boundaries
//   busy, done             dump in progress, one-cycle completion pulse
//   fb_rd_en/x/y, fb_rd_data  frame buffer read port (data 1 cycle after en)
//   tx_data, tx_valid, tx_ready  byte stream to the UART transmitter
module fb_uart_dump
  import fb_dump_pkg::*;
#(
  parameter int unsigned H_PIX = NES_H_PIX,
  parameter int unsigned V_PIX = NES_V_PIX,
  parameter logic [7:0]  SYNC0 = FB_SYNC0,
  parameter logic [7:0]  SYNC1 = FB_SYNC1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       fb_rd_en,
  output logic [7:0] fb_rd_x,
  output logic [7:0] fb_rd_y,
  input  logic [5:0] fb_rd_data,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready
);

  localparam logic [7:0] X_LAST = 8'(H_PIX - 1);
  localparam logic [7:0] Y_LAST = 8'(V_PIX - 1);

  fb_dump_state_t state;
  logic [7:0]     x_cnt;
  logic [7:0]     y_cnt;
`ifdef FB_DUMP_CSUM_EN
  logic [7:0]     csum;
`endif

  logic           hs;
  logic           last_x;
  logic           last_pix;
  logic [7:0]     nx;
  logic [7:0]     ny;
  color_idx_t     pix;

  // Raster-order successor of the current pixel.
  always_comb begin
    hs       = tx_valid && tx_ready;
    last_x   = (x_cnt == X_LAST);
    last_pix = last_x && (y_cnt == Y_LAST);
    nx       = last_x ? 8'd0 : x_cnt + 8'd1;
    ny       = last_x ? y_cnt + 8'd1 : y_cnt;
    pix      = fb_rd_data;
  end

  // Dump FSM with registered outputs. done and fb_rd_en default low so they
  // are high only for the single cycle spent in FIN and RD respectively.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      fb_rd_en <= 1'b0;
      fb_rd_x  <= 8'd0;
      fb_rd_y  <= 8'd0;
      tx_data  <= 8'd0;
      tx_valid <= 1'b0;
      x_cnt    <= 8'd0;
      y_cnt    <= 8'd0;
`ifdef FB_DUMP_CSUM_EN
      csum     <= 8'd0;
`endif
    end else begin
      done     <= 1'b0;
      fb_rd_en <= 1'b0;
      case (state)
        // abort is deliberately not looked at here: start wins
        ST_IDLE: begin
          if (start) begin
            state    <= ST_HDR0;
            busy     <= 1'b1;
            tx_valid <= 1'b1;
            tx_data  <= SYNC0;
            x_cnt    <= 8'd0;
            y_cnt    <= 8'd0;
`ifdef FB_DUMP_CSUM_EN
            csum     <= 8'd0;
`endif
          end
        end
        ST_HDR0: begin
          if (hs) begin
            if (abort) begin
              state    <= ST_IDLE;
              busy     <= 1'b0;
              tx_valid <= 1'b0;
            end else begin
              state   <= ST_HDR1;
              tx_data <= SYNC1;
            end
          end
        end
        ST_HDR1: begin
          if (hs) begin
            tx_valid <= 1'b0;
            if (abort) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              state    <= ST_RD;
              fb_rd_en <= 1'b1;
              fb_rd_x  <= x_cnt;
              fb_rd_y  <= y_cnt;
            end
          end
        end
        ST_RD: begin
          if (abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            state <= ST_CAP;
          end
        end
        ST_CAP: begin
          if (abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            state    <= ST_SEND;
            tx_data  <= {2'b00, pix};
            tx_valid <= 1'b1;
`ifdef FB_DUMP_CSUM_EN
            csum     <= csum + {2'b00, pix};
`endif
          end
        end
        ST_SEND: begin
          if (hs) begin
            tx_valid <= 1'b0;
            if (abort) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else if (last_pix) begin
`ifdef FB_DUMP_CSUM_EN
              state    <= ST_CSUM;
              tx_valid <= 1'b1;
              tx_data  <= csum;
`else
              state    <= ST_FIN;
              done     <= 1'b1;
`endif
            end else begin
              state    <= ST_RD;
              x_cnt    <= nx;
              y_cnt    <= ny;
              fb_rd_en <= 1'b1;
              fb_rd_x  <= nx;
              fb_rd_y  <= ny;
            end
          end
        end
`ifdef FB_DUMP_CSUM_EN
        ST_CSUM: begin
          if (hs) begin
            tx_valid <= 1'b0;
            if (abort) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              state <= ST_FIN;
              done  <= 1'b1;
            end
          end
        end
`endif
        ST_FIN: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          busy     <= 1'b0;
          tx_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fb_uart_dump.sv
// Self-checking bench for fb_uart_dump on a reduced 80x6 frame so every
// scenario dumps a complete frame. A frame-buffer model answers reads one
// cycle later; the expected byte stream is built directly from the frame
// contents.
module tb_fb_uart_dump;

  localparam int H     = 80;
  localparam int V     = 6;
  localparam int NPIX  = H * V;
  localparam int LIMIT = 20000;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic       busy;
  logic       done;
  logic       fb_rd_en;
  logic [7:0] fb_rd_x;
  logic [7:0] fb_rd_y;
  logic [5:0] fb_rd_data;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  fb_uart_dump #(.H_PIX(H), .V_PIX(V)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .fb_rd_en   (fb_rd_en),
    .fb_rd_x    (fb_rd_x),
    .fb_rd_y    (fb_rd_y),
    .fb_rd_data (fb_rd_data),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [5:0]  mem [NPIX];
  logic [7:0]  exp_q [$];
  logic [7:0]  rx [$];
  logic [15:0] rd_q [$];
  int          done_cnt   = 0;
  int          stall_viol = 0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data  = 8'd0;
  int          checks = 0;
  int          errors = 0;

  // Frame buffer: data valid exactly one cycle after the strobe, junk otherwise.
  always @(posedge clk) begin
    if (fb_rd_en && (int'(fb_rd_y) < V) && (int'(fb_rd_x) < H))
      fb_rd_data <= mem[int'(fb_rd_y) * H + int'(fb_rd_x)];
    else
      fb_rd_data <= 6'($urandom);
  end

  // Monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (tx_valid && tx_ready) rx.push_back(tx_data);
    if (done) done_cnt++;
    if (fb_rd_en) rd_q.push_back({fb_rd_y, fb_rd_x});
    if (!rst && prev_stall && (!tx_valid || tx_data != prev_data)) stall_viol++;
    prev_stall = !rst && tx_valid && !tx_ready;
    prev_data  = tx_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic rdy_val(input int mode);
    if (mode == 0) return 1'b1;
    if (mode == 1) return ($urandom_range(0, 99) < 30);
    return 1'b0;
  endfunction

  task automatic fill_mem(input int mode);
    for (int i = 0; i < NPIX; i++) begin
      case (mode)
        0:       mem[i] = 6'(i % H);
        1:       mem[i] = 6'h27;
        2:       mem[i] = (i == 0) ? 6'h15 : 6'h00;
        default: mem[i] = 6'($urandom);
      endcase
    end
  endtask

  // Expected stream: header, one byte per pixel, optional byte sum.
  task automatic build_exp();
    int sum;
    sum = 0;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    for (int i = 0; i < NPIX; i++) begin
      exp_q.push_back({2'b00, mem[i]});
      sum += int'(mem[i]);
    end
`ifdef FB_DUMP_CSUM_EN
    exp_q.push_back(8'(sum % 256));
`endif
  endtask

  task automatic check_stream(input string name, input int base);
    int bad;
    bad = -1;
    checks++;
    if (rx.size() - base != exp_q.size()) bad = -2;
    else
      for (int i = 0; i < exp_q.size(); i++)
        if (bad == -1 && rx[base + i] !== exp_q[i]) bad = i;
    if (bad != -1) begin
      errors++;
      $display("FAIL %s: got %0d bytes expected %0d, first differing byte %0d",
               name, rx.size() - base, exp_q.size(), bad);
    end
  endtask

  task automatic check_reads(input string name, input int rbase, input int n);
    int bad;
    bad = -1;
    checks++;
    if (rd_q.size() - rbase != n) bad = -2;
    else
      for (int i = 0; i < n; i++)
        if (bad == -1 && rd_q[rbase + i] !== {8'(i / H), 8'(i % H)}) bad = i;
    if (bad != -1) begin
      errors++;
      $display("FAIL %s: got %0d reads expected %0d, first out-of-order read %0d",
               name, rd_q.size() - rbase, n, bad);
    end
  endtask

  task automatic run_dump(input int rdy_mode, input bit noise, input bit with_abort,
                          output int cyc);
    start    = 1'b1;
    abort    = with_abort;
    tx_ready = rdy_val(rdy_mode);
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("start_latency_valid", 32'(tx_valid), 32'd1);
    chk("start_latency_sync0", 32'(tx_data), 32'hA5);
    cyc = 0;
    while (busy && cyc < LIMIT) begin
      tx_ready = rdy_val(rdy_mode);
      start    = noise && ($urandom_range(0, 7) == 0);
      tick();
      cyc++;
    end
    start = 1'b0;
    chk("dump_timeout", 32'(cyc < LIMIT), 32'd1);
  endtask

  typedef struct {
    int fb_mode;
    int rdy_mode;
    bit noise;
    bit with_abort;
    int exp_csum;   // -1: not checked
    bit byte_tab;
  } scen_t;

  typedef struct {
    int         idx;
    logic [7:0] val;
  } byte_chk_t;

  scen_t     scen [6];
  byte_chk_t btab [9];

  initial begin
    int cyc, base, dbase, rbase, sbase, n;

    // 480 * 0x27 = 18720 = 73*256 + 0x20
    scen[0] = '{0, 0, 1'b0, 1'b0, -1,    1'b1};
    scen[1] = '{1, 0, 1'b0, 1'b0, 'h20,  1'b0};
    scen[2] = '{2, 0, 1'b0, 1'b0, 'h15,  1'b0};
    scen[3] = '{3, 1, 1'b0, 1'b0, -1,    1'b0};
    scen[4] = '{0, 1, 1'b1, 1'b0, -1,    1'b1};
    scen[5] = '{3, 0, 1'b0, 1'b1, -1,    1'b0};

    // x-pattern frame: byte k>=2 is pixel k-2, value x[5:0], 80 pixels per line
    btab[0] = '{0,  8'hA5};
    btab[1] = '{1,  8'h5A};
    btab[2] = '{2,  8'h00};
    btab[3] = '{3,  8'h01};
    btab[4] = '{4,  8'h02};
    btab[5] = '{65, 8'h3F};
    btab[6] = '{66, 8'h00};
    btab[7] = '{81, 8'h0F};
    btab[8] = '{82, 8'h00};

    rst = 1'b1; start = 1'b0; abort = 1'b0; tx_ready = 1'b0;
    repeat (3) tick();
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_done",     32'(done),     32'd0);
    chk("rst_rd_en",    32'(fb_rd_en), 32'd0);
    chk("rst_rd_x",     32'(fb_rd_x),  32'd0);
    chk("rst_rd_y",     32'(fb_rd_y),  32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data",  32'(tx_data),  32'd0);
    rst = 1'b0;
    repeat (2) tick();

    foreach (scen[s]) begin
      fill_mem(scen[s].fb_mode);
      build_exp();
      base  = rx.size();
      dbase = done_cnt;
      rbase = rd_q.size();
      sbase = stall_viol;
      run_dump(scen[s].rdy_mode, scen[s].noise, scen[s].with_abort, cyc);
      tick();
      check_stream($sformatf("stream_s%0d", s), base);
      chk($sformatf("done_once_s%0d", s), 32'(done_cnt - dbase), 32'd1);
      check_reads($sformatf("reads_s%0d", s), rbase, NPIX);
      chk($sformatf("stall_stable_s%0d", s), 32'(stall_viol - sbase), 32'd0);
      chk($sformatf("idle_busy_s%0d", s), 32'(busy), 32'd0);
      if (scen[s].byte_tab)
        foreach (btab[b])
          chk($sformatf("byte%0d_s%0d", btab[b].idx, s),
              (base + btab[b].idx < rx.size()) ? 32'(rx[base + btab[b].idx]) : 32'hDEAD,
              32'(btab[b].val));
`ifdef FB_DUMP_CSUM_EN
      if (scen[s].exp_csum >= 0)
        chk($sformatf("csum_s%0d", s),
            (rx.size() > base) ? 32'(rx[rx.size() - 1]) : 32'hDEAD,
            32'(scen[s].exp_csum));
`endif
      repeat (2) tick();
    end

    // Abort while pixel (10,3) (byte 252) is stalled.
    fill_mem(0);
    build_exp();
    base  = rx.size();
    dbase = done_cnt;
    rbase = rd_q.size();
    start = 1'b1; tx_ready = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (rx.size() - base < 252 && n < LIMIT) begin tick(); n++; end
    tx_ready = 1'b0;
    n = 0;
    while (!tx_valid && n < 10) begin tick(); n++; end
    chk("abort_reach_pixel", 32'(tx_valid), 32'd1);
    abort = 1'b1;
    repeat (3) begin
      tick();
      chk("abort_hold_valid", 32'(tx_valid), 32'd1);
      chk("abort_hold_data",  32'(tx_data),  32'h0A);
    end
    tx_ready = 1'b1;
    tick();
    chk("abort_idle_busy",  32'(busy),     32'd0);
    chk("abort_idle_valid", 32'(tx_valid), 32'd0);
    abort = 1'b0; tx_ready = 1'b0;
    repeat (4) tick();
    chk("abort_byte_count", 32'(rx.size() - base), 32'd253);
    chk("abort_last_byte", (rx.size() > base + 252) ? 32'(rx[base + 252]) : 32'hDEAD, 32'h0A);
    chk("abort_no_done",   32'(done_cnt - dbase), 32'd0);
    chk("abort_reads",     32'(rd_q.size() - rbase), 32'd251);

    // Reset mid-dump, then a full dump from the header again.
    fill_mem(3);
    build_exp();
    base  = rx.size();
    dbase = done_cnt;
    start = 1'b1; tx_ready = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (rx.size() - base < 300 && n < LIMIT) begin tick(); n++; end
    rst = 1'b1;
    #1;
    chk("midrst_busy",     32'(busy),     32'd0);
    chk("midrst_done",     32'(done),     32'd0);
    chk("midrst_rd_en",    32'(fb_rd_en), 32'd0);
    chk("midrst_rd_x",     32'(fb_rd_x),  32'd0);
    chk("midrst_rd_y",     32'(fb_rd_y),  32'd0);
    chk("midrst_tx_valid", 32'(tx_valid), 32'd0);
    chk("midrst_tx_data",  32'(tx_data),  32'd0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("midrst_no_done", 32'(done_cnt - dbase), 32'd0);
    base  = rx.size();
    dbase = done_cnt;
    run_dump(0, 1'b0, 1'b0, cyc);
    tick();
    check_stream("stream_after_rst", base);
    chk("done_after_rst", 32'(done_cnt - dbase), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
